adc_scan_sequencer: RTL and testbench

ADC_SCAN_SEQUENCER -- requirements
Module: adc_scan_sequencer

---
 rtl/adc_scan_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_adc_scan_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_sequencer.sv
// Scan sequencer for a 6-channel 12-bit serial ADC: issues 7 address/data frames
// per scan, collects results in shadow registers and publishes them atomically.
module adc_scan_sequencer #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] adc_cmd,
  output logic [7:0] status,
  output logic [7:0] ch0_upper,
  output logic [7:0] ch0_lower,
  output logic [7:0] ch1_upper,
  output logic [7:0] ch1_lower,
  output logic [7:0] ch2_upper,
  output logic [7:0] ch2_lower,
  output logic [7:0] ch3_upper,
  output logic [7:0] ch3_lower,
  output logic [7:0] ch4_upper,
  output logic [7:0] ch4_lower,
  output logic [7:0] ch5_upper,
  output logic [7:0] ch5_lower,
  output logic       adc_cs_n,
  output logic       adc_sclk,
  output logic       adc_din,
  input  logic       adc_dout
);

  typedef enum logic [1:0] {IDLE = 2'd0, SETUP = 2'd1, SHIFT = 2'd2, GAP = 2'd3} state_t;

  localparam int unsigned DW = 9;
  localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] GAP_LAST  = DW'(2 * CLK_DIV - 1);

  state_t            state_q, state_d;
  logic [1:0]        cmd_q, cmd_d;
  logic              pend_q, pend_d;
  logic [DW-1:0]     div_q, div_d;
  logic [3:0]        bit_q, bit_d;
  logic [2:0]        frm_q, frm_d;
  logic              sclk_q, sclk_d;
  logic              din_q, din_d;
  logic              cs_n_q, cs_n_d;
  logic [11:0]       sh_q, sh_d;
  logic [5:0][11:0]  shadow_q, shadow_d;
  logic [5:0][11:0]  res_q, res_d;
  logic              upd_q, upd_d;
  logic              dv_q, dv_d;
  logic              zero_q, zero_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              cmd_edge, start, div_done, last_bit, rise;
  logic              unused_cmd;

  assign unused_cmd = ^adc_cmd[7:2];

  // Frame f carries address f on bits 2..4; the trailing frame only clocks out data.
  function automatic logic din_bit(input logic [2:0] frm, input logic [3:0] bitn);
    logic [2:0] addr;
    addr = (frm < 3'd6) ? frm : 3'd0;
    case (bitn)
      4'd2:    din_bit = addr[2];
      4'd3:    din_bit = addr[1];
      4'd4:    din_bit = addr[0];
      default: din_bit = 1'b0;
    endcase
  endfunction

  always_comb begin
    cmd_edge = adc_cmd[0] & ~cmd_q[0];
    start    = cmd_edge | pend_q | cmd_q[1];
    div_done = (state_q == GAP) ? (div_q == GAP_LAST) : (div_q == HALF_LAST);
    last_bit = (frm_q == 3'd6) && (bit_q == 4'd15);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (div_done) state_d = SHIFT;
      SHIFT:   if (div_done && sclk_q && last_bit) state_d = GAP;
      GAP:     if (div_done) state_d = start ? SETUP : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_d    = adc_cmd[1:0];
    div_d    = (state_q == IDLE || div_done || state_d != state_q) ? '0 : div_q + DW'(1);
    bit_d    = bit_q;
    frm_d    = frm_q;
    sclk_d   = sclk_q;
    din_d    = din_q;
    sh_d     = sh_q;
    shadow_d = shadow_q;
    rise     = 1'b0;
    cs_n_d   = !(state_d == SETUP || state_d == SHIFT);

    // A scan launch consumes any request; an edge seen while busy is parked once.
    pend_d = pend_q;
    if ((state_q == IDLE || state_q == GAP) && state_d == SETUP) pend_d = 1'b0;
    else if (cmd_edge && state_q != IDLE)                        pend_d = 1'b1;

    case (state_q)
      SETUP: begin
        bit_d = 4'd0;
        frm_d = 3'd0;
        if (div_done) begin
          sclk_d = 1'b0;
          din_d  = din_bit(3'd0, 4'd0);
        end
      end
      SHIFT: begin
        if (div_done) begin
          if (!sclk_q) begin
            sclk_d = 1'b1;
            rise   = 1'b1;
          end else if (!last_bit) begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 4'd1;
            if (bit_q == 4'd15) frm_d = frm_q + 3'd1;
            din_d  = din_bit(frm_d, bit_d);
          end else begin
            din_d  = 1'b0;
          end
        end
      end
      default: begin
        sclk_d = 1'b1;
        din_d  = 1'b0;
        bit_d  = 4'd0;
        frm_d  = 3'd0;
      end
    endcase

    // Data bits 4..15 shift in MSB first; frame f holds channel f-1.
    if (rise) begin
      if (bit_q >= 4'd4) sh_d = {sh_q[10:0], adc_dout};
      if (bit_q == 4'd15 && frm_q != 3'd0) shadow_d[frm_q - 3'd1] = {sh_q[10:0], adc_dout};
    end
    upd_d = rise && last_bit;

    res_d  = res_q;
    dv_d   = dv_q;
    zero_d = zero_q;
    cnt_d  = cnt_q;
    if (upd_q) begin
      res_d  = shadow_q;
      dv_d   = 1'b1;
      zero_d = (shadow_q == '0);
      cnt_d  = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_q    <= '0;
      pend_q   <= 1'b0;
      div_q    <= '0;
      bit_q    <= '0;
      frm_q    <= '0;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      sh_q     <= '0;
      shadow_q <= '0;
      res_q    <= '0;
      upd_q    <= 1'b0;
      dv_q     <= 1'b0;
      zero_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      cmd_q    <= cmd_d;
      pend_q   <= pend_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      frm_q    <= frm_d;
      sclk_q   <= sclk_d;
      din_q    <= din_d;
      cs_n_q   <= cs_n_d;
      sh_q     <= sh_d;
      shadow_q <= shadow_d;
      res_q    <= res_d;
      upd_q    <= upd_d;
      dv_q     <= dv_d;
      zero_q   <= zero_d;
      cnt_q    <= cnt_d;
    end
  end

  assign adc_cs_n = cs_n_q;
  assign adc_sclk = sclk_q;
  assign adc_din  = din_q;
  assign status   = {cnt_q, zero_q, dv_q, cmd_q[1], state_q != IDLE};

  assign ch0_upper = {4'b0, res_q[0][11:8]};
  assign ch0_lower = res_q[0][7:0];
  assign ch1_upper = {4'b0, res_q[1][11:8]};
  assign ch1_lower = res_q[1][7:0];
  assign ch2_upper = {4'b0, res_q[2][11:8]};
  assign ch2_lower = res_q[2][7:0];
  assign ch3_upper = {4'b0, res_q[3][11:8]};
  assign ch3_lower = res_q[3][7:0];
  assign ch4_upper = {4'b0, res_q[4][11:8]};
  assign ch4_lower = res_q[4][7:0];
  assign ch5_upper = {4'b0, res_q[5][11:8]};
  assign ch5_lower = res_q[5][7:0];

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Bench for adc_scan_sequencer: serial ADC model, din protocol checker and a
// scoreboard that checks every published result set against queued expectations.
module tb_adc_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] adc_cmd = 8'h00;
  logic [7:0] status;
  logic [7:0] ch0_upper, ch0_lower, ch1_upper, ch1_lower, ch2_upper, ch2_lower;
  logic [7:0] ch3_upper, ch3_lower, ch4_upper, ch4_lower, ch5_upper, ch5_lower;
  logic       adc_cs_n, adc_sclk, adc_din;
  logic       adc_dout = 1'b0;

  always #5 clk = ~clk;

  adc_scan_sequencer #(.CLK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .adc_cmd(adc_cmd), .status(status),
    .ch0_upper(ch0_upper), .ch0_lower(ch0_lower), .ch1_upper(ch1_upper), .ch1_lower(ch1_lower),
    .ch2_upper(ch2_upper), .ch2_lower(ch2_lower), .ch3_upper(ch3_upper), .ch3_lower(ch3_lower),
    .ch4_upper(ch4_upper), .ch4_lower(ch4_lower), .ch5_upper(ch5_upper), .ch5_lower(ch5_lower),
    .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk), .adc_din(adc_din), .adc_dout(adc_dout)
  );

  logic [95:0] chs;
  assign chs = {ch5_upper, ch5_lower, ch4_upper, ch4_lower, ch3_upper, ch3_lower,
                ch2_upper, ch2_lower, ch1_upper, ch1_lower, ch0_upper, ch0_lower};

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
  endtask

  // ADC model: value for channel k is 0x100*k+0x23, optionally xor-masked or forced to 0.
  logic [11:0] mask = 12'h000;
  logic        zero_mode = 1'b0;
  int          n_edge = 0;
  logic [2:0]  addr_cur = 3'd0, prev_addr = 3'd0;
  logic        din_rise = 1'b0, din_bad = 1'b0;

  function automatic logic [11:0] model_val(input logic [2:0] a);
    return zero_mode ? 12'h000 : ({1'b0, a, 8'h23} ^ mask);
  endfunction

  always @(negedge adc_cs_n) begin
    n_edge    = 0;
    addr_cur  = 3'd0;
    prev_addr = 3'd0;
    din_rise  = 1'b0;
    din_bad   = 1'b0;
  end

  always @(negedge adc_sclk) begin
    if (rst_n && !adc_cs_n) begin
      int f, b;
      logic [11:0] v;
      f = n_edge / 16;
      b = n_edge % 16;
      v = model_val(prev_addr);
      adc_dout = (f == 0 || b < 4) ? 1'b0 : v[15 - b];
      n_edge++;
    end
  end

  always @(posedge adc_sclk) begin
    if (rst_n && !adc_cs_n) begin
      int f, b;
      logic [2:0] ea;
      f = (n_edge - 1) / 16;
      b = (n_edge - 1) % 16;
      din_rise = adc_din;
      if (b >= 2 && b <= 4) addr_cur = {addr_cur[1:0], adc_din};
      else if (adc_din !== 1'b0) din_bad = 1'b1;
      if (b == 15) begin
        ea = (f < 6) ? 3'(f) : 3'd0;
        chk($sformatf("din_frame%0d", f), {din_bad, addr_cur}, {1'b0, ea});
        prev_addr = addr_cur;
        addr_cur  = 3'd0;
        din_bad   = 1'b0;
      end
    end
  end

  always @(negedge clk)
    if (rst_n && !adc_cs_n && adc_sclk && adc_din !== din_rise) din_bad = 1'b1;

  // Scoreboard
  typedef struct {
    logic [95:0] chs;
    logic [5:0]  st;
  } exp_t;

  exp_t sbq[$];
  exp_t e_mon;
  int   exp_cnt = 0;

  task automatic push_scan(input logic [11:0] m, input logic z);
    exp_t e;
    logic [11:0] v;
    exp_cnt = (exp_cnt + 1) % 16;
    for (int k = 0; k < 6; k++) begin
      v = z ? 12'h000 : ({1'b0, 3'(k), 8'h23} ^ m);
      e.chs[k*16 +: 16] = {4'b0, v[11:8], v[7:0]};
    end
    e.st = {4'(exp_cnt), z, 1'b1};
    sbq.push_back(e);
  endtask

  logic [3:0]  prev_cnt = 4'd0;
  logic [95:0] prev_chs = '0;
  logic        tear = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_cnt = status[7:4];
      prev_chs = chs;
      tear     = 1'b0;
    end else begin
      if (status[7:4] != prev_cnt) begin
        chk("sb_expected_avail", sbq.size() > 0, 1'b1);
        if (sbq.size() > 0) begin
          e_mon = sbq.pop_front();
          chk("sb_chs", chs, e_mon.chs);
          chk("sb_status", status[7:2], e_mon.st);
          chk("sb_no_tear", tear, 1'b0);
        end
        tear = 1'b0;
      end else if (chs != prev_chs) begin
        tear = 1'b1;
      end
      prev_cnt = status[7:4];
      prev_chs = chs;
    end
  end

  task automatic wait_cs(input logic lvl, input int lim, output int n);
    n = 0;
    while (adc_cs_n !== lvl && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (adc_cs_n !== lvl) chk("timeout_cs", adc_cs_n, lvl);
  endtask

  task automatic wait_idle(input int lim);
    int n;
    n = 0;
    while (status[0] !== 1'b0 && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (status[0] !== 1'b0) chk("timeout_idle", status[0], 1'b0);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    exp_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_cs_n", adc_cs_n, 1'b1);
    chk("rst_sclk", adc_sclk, 1'b1);
    chk("rst_din", adc_din, 1'b0);
    chk("rst_status", status, 8'h00);
    chk("rst_chs", chs, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single scan on a bit0 rising edge
    adc_cmd = 8'h01;
    push_scan(12'h000, 1'b0);
    wait_cs(1'b0, 20, n);
    wait_cs(1'b1, 2000, n);
    chk("scan_cs_low_cycles", n, 900);
    chk("scan_sclk_falls", n_edge, 112);
    wait_idle(50);
    chk("t1_status", status, 8'h14);
    chk("t1_ch3_upper", ch3_upper, 8'h03);
    chk("t1_ch3_lower", ch3_lower, 8'h23);
    chk("t1_ch5_upper", ch5_upper, 8'h05);
    adc_cmd = 8'h00;
    do_reset();

    // Auto mode for three scans, cleared during the third
    adc_cmd = 8'h02;
    repeat (3) push_scan(12'h000, 1'b0);
    wait_cs(1'b0, 20, n);
    @(negedge clk);
    chk("auto_busy_bits", status[1:0], 2'b11);
    wait_cs(1'b1, 2000, n);
    wait_cs(1'b0, 50, n);
    chk("auto_gap1", n, 8);
    wait_cs(1'b1, 2000, n);
    wait_cs(1'b0, 50, n);
    chk("auto_gap2", n, 8);
    adc_cmd = 8'h00;
    wait_cs(1'b1, 2000, n);
    wait_idle(50);
    chk("t2_status", status, 8'h34);
    repeat (20) @(negedge clk);
    chk("t2_stays_idle", {status[0], adc_cs_n}, 2'b01);
    do_reset();

    // Pending request: one edge during scan 1, two edges during scan 2
    adc_cmd = 8'h01;
    push_scan(12'h000, 1'b0);
    wait_cs(1'b0, 20, n);
    repeat (50) @(negedge clk);
    adc_cmd = 8'h00;
    repeat (50) @(negedge clk);
    adc_cmd = 8'h01;
    push_scan(12'h000, 1'b0);
    wait_cs(1'b1, 2000, n);
    wait_cs(1'b0, 50, n);
    chk("pend_gap1", n, 8);
    repeat (50) @(negedge clk);
    adc_cmd = 8'h00;
    repeat (50) @(negedge clk);
    adc_cmd = 8'h01;
    push_scan(12'h000, 1'b0);
    repeat (50) @(negedge clk);
    adc_cmd = 8'h00;
    repeat (50) @(negedge clk);
    adc_cmd = 8'h01;
    wait_cs(1'b1, 2000, n);
    wait_cs(1'b0, 50, n);
    chk("pend_gap2", n, 8);
    wait_cs(1'b1, 2000, n);
    wait_idle(50);
    repeat (30) @(negedge clk);
    chk("t3_status", status, 8'h34);
    adc_cmd = 8'h00;
    @(negedge clk);

    // Model data changed early in the scan: all channels take new values together
    adc_cmd = 8'h01;
    push_scan(12'hA5A, 1'b0);
    wait_cs(1'b0, 20, n);
    repeat (20) @(negedge clk);
    mask = 12'hA5A;
    wait_cs(1'b1, 2000, n);
    wait_idle(50);
    chk("t4_ch2_upper", ch2_upper, 8'h08);
    chk("t4_ch2_lower", ch2_lower, 8'h79);
    adc_cmd = 8'h00;
    @(negedge clk);

    // All-zero conversion data sets the zero flag
    adc_cmd   = 8'h01;
    zero_mode = 1'b1;
    push_scan(12'h000, 1'b1);
    wait_cs(1'b0, 20, n);
    wait_cs(1'b1, 2000, n);
    wait_idle(50);
    chk("t5_status", status, 8'h5C);
    adc_cmd   = 8'h00;
    zero_mode = 1'b0;
    mask      = 12'h000;
    @(negedge clk);

    // Reset mid-scan aborts without publishing
    adc_cmd = 8'h01;
    wait_cs(1'b0, 20, n);
    repeat (450) @(negedge clk);
    chk("abort_pre_cs", adc_cs_n, 1'b0);
    #2;
    rst_n   = 1'b0;
    adc_cmd = 8'h00;
    exp_cnt = 0;
    #1;
    chk("abort_cs_n", adc_cs_n, 1'b1);
    chk("abort_status", status, 8'h00);
    chk("abort_chs", chs, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_idle", {status, adc_cs_n}, {8'h00, 1'b1});
    chk("abort_chs_after", chs, '0);
    chk("sb_drained", sbq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, want finished");
    $fatal(1);
  end

endmodule
